// File: rtl/fir_mac_if.sv
// Handshake, coefficient and multiplier signal bundle for fir_mac_sequencer.
// slave is the sequencer's view; master is the surrounding system's view.
interface fir_mac_if #(
  parameter int TAPS = 8
);
  localparam int AW = $clog2(TAPS);

  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [31:0]   coef_data;
  logic          coef_err;
  logic          mul_vld;
  logic [31:0]   mul_a;
  logic [31:0]   mul_b;
  logic [63:0]   mul_p;
  logic          y_valid;
  logic [63:0]   y_data;
  logic          y_ready;

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data, mul_p, y_ready,
    output in_ready, coef_err, mul_vld, mul_a, mul_b, y_valid, y_data
  );

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data, mul_p, y_ready,
    input  in_ready, coef_err, mul_vld, mul_a, mul_b, y_valid, y_data
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// One-sample-at-a-time FIR that time-shares an external pipelined multiplier.
// state | meaning
// IDLE  | waiting for a sample; coefficient writes allowed
// ISSUE | one tap per cycle sent to the multiplier, k = 0..TAPS-1
// DRAIN | waiting for the remaining products to return
// DONE  | result held on y_data until y_ready
module fir_mac_sequencer #(
  parameter int TAPS    = 8,
  parameter int MUL_LAT = 2
) (
  input  logic     clk,
  input  logic     rst,
  fir_mac_if.slave bus
);
  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [31:0]          x_q [TAPS];
  logic [31:0]          h_q [TAPS];
  logic [AW-1:0]        k_q;
  logic [AW-1:0]        ret_q;
  logic [MUL_LAT-1:0]   vld_sr_q;
  logic [63:0]          acc_q;
  logic [63:0]          y_q;
  logic                 err_q;

  logic                 accept;
  logic                 prod_vld;
  logic                 last_ret;
  logic [63:0]          acc_next;
  logic                 in_ready;
  logic                 mul_vld;
  logic [31:0]          mul_a;
  logic [31:0]          mul_b;

  assign prod_vld = vld_sr_q[MUL_LAT-1];
  assign last_ret = prod_vld && (ret_q == LAST);
  assign acc_next = acc_q + bus.mul_p;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    mul_vld  = 1'b0;
    mul_a    = '0;
    mul_b    = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mul_vld = 1'b1;
        mul_a   = x_q[k_q];
        mul_b   = h_q[k_q];
        if (k_q == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_ret) state_d = DONE;
      end
      DONE: begin
        if (bus.y_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      ret_q    <= '0;
      vld_sr_q <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      err_q   <= bus.coef_we && (state_q != IDLE);
      if (bus.coef_we && (state_q == IDLE)) h_q[bus.coef_addr] <= bus.coef_data;

      // Tracks issued operands so only real products reach the accumulator.
      vld_sr_q[0] <= mul_vld;
      for (int i = 1; i < MUL_LAT; i++) vld_sr_q[i] <= vld_sr_q[i-1];

      if (accept) begin
        x_q[0] <= bus.in_data;
        for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
        acc_q <= '0;
        k_q   <= '0;
        ret_q <= '0;
      end else begin
        if (state_q == ISSUE) k_q <= k_q + AW'(1);
        if (prod_vld) begin
          acc_q <= acc_next;
          ret_q <= ret_q + AW'(1);
        end
      end

      if (last_ret) y_q <= acc_next;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.coef_err = err_q;
  assign bus.mul_vld  = mul_vld;
  assign bus.mul_a    = mul_a;
  assign bus.mul_b    = mul_b;
  assign bus.y_valid  = (state_q == DONE);
  assign bus.y_data   = y_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a pipelined multiplier model and
// an output scoreboard checked by an independent monitor.
module tb_fir_mac_sequencer;
  localparam int TAPS    = 8;
  localparam int MUL_LAT = 2;
  localparam int LAT     = TAPS + MUL_LAT + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_mac_if #(.TAPS(TAPS)) bus ();

  fir_mac_sequencer #(.TAPS(TAPS), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int err_pulses = 0;

  typedef struct {
    logic [63:0] data;
    int          acc_cyc;
    int          tag;
  } exp_t;
  exp_t sb[$];
  int   tag_n = 0;

  logic [63:0] ramp_exp [8] = '{64'd13, 64'd15, 64'd18, 64'd22, 64'd27, 64'd33, 64'd35, 64'd36};

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: garbage when idle so ignored products would show up.
  logic [63:0] pipe [MUL_LAT];
  always @(posedge clk) begin
    if (bus.mul_vld)
      pipe[0] <= $signed({{32{bus.mul_a[31]}}, bus.mul_a}) * $signed({{32{bus.mul_b[31]}}, bus.mul_b});
    else
      pipe[0] <= 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mul_p = pipe[MUL_LAT-1];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst && bus.coef_err) err_pulses++;

  logic yv_q = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      yv_q = 1'b0;
    end else begin
      if (bus.y_valid && !yv_q) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got y_data=%0h expected no output", bus.y_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("y_data[%0d]", e.tag), bus.y_data, e.data);
          chk($sformatf("latency[%0d]", e.tag), 64'(cyc - e.acc_cyc), 64'(LAT));
        end
      end
      yv_q = bus.y_valid;
    end
  end

  task automatic timeout(string nm);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // Called at a negedge; returns at the negedge of the first ISSUE cycle.
  task automatic send(logic [31:0] d, logic [63:0] exp, bit push);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      timeout("send_wait_ready");
      bus.in_valid = 1'b0;
      return;
    end
    if (push) begin
      sb.push_back('{exp, cyc, tag_n});
      tag_n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) timeout("wait_idle");
  endtask

  task automatic wr_coef(logic [2:0] a, logic [31:0] d);
    bus.coef_we   = 1'b1;
    bus.coef_addr = a;
    bus.coef_data = d;
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.y_ready   = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mul_vld", 64'(bus.mul_vld), 64'd0);
    chk("rst_mul_a",   64'(bus.mul_a),   64'd0);
    chk("rst_mul_b",   64'(bus.mul_b),   64'd0);
    chk("rst_y_valid", 64'(bus.y_valid), 64'd0);
    chk("rst_y_data",  bus.y_data,       64'd0);
    chk("rst_coef_err", 64'(bus.coef_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single tap, positive and negative coefficient.
    wr_coef(3'd0, 32'd3);
    send(32'd5, 64'd15, 1'b1);
    wait_idle();
    wr_coef(3'd0, 32'hFFFF_FFFE);
    send(32'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b1);
    wait_idle();

    // All-ones coefficients: running window sums.
    for (int k = 0; k < TAPS; k++) wr_coef(3'(k), 32'd1);
    for (int i = 0; i < 8; i++) begin
      send(32'(i + 1), ramp_exp[i], 1'b1);
      wait_idle();
    end
    send(32'd0, 64'd35, 1'b1);
    wait_idle();

    // Back-pressure in DONE.
    bus.y_ready = 1'b0;
    send(32'd0, 64'd33, 1'b1);
    n = 0;
    while (!bus.y_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.y_valid) timeout("hold_wait_valid");
    for (int i = 0; i < 5; i++) begin
      chk("hold_y_valid",  64'(bus.y_valid),  64'd1);
      chk("hold_y_data",   bus.y_data,        64'd33);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_mul_vld",  64'(bus.mul_vld),  64'd0);
      @(negedge clk);
    end
    bus.y_ready = 1'b1;
    @(negedge clk);
    chk("release_y_valid",  64'(bus.y_valid),  64'd0);
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);

    // Coefficient write while busy is rejected.
    chk("err_none_in_idle", 64'(err_pulses), 64'd0);
    send(32'd10, 64'd40, 1'b1);
    wr_coef(3'd0, 32'd100);
    wait_idle();
    chk("err_one_pulse", 64'(err_pulses), 64'd1);
    send(32'd2, 64'd38, 1'b1);
    wait_idle();

    // Reset in the third ISSUE cycle, then coefficient write and sample together.
    send(32'd9, 64'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mul_vld",  64'(bus.mul_vld),  64'd0);
    chk("abort_mul_a",    64'(bus.mul_a),    64'd0);
    chk("abort_mul_b",    64'(bus.mul_b),    64'd0);
    chk("abort_y_valid",  64'(bus.y_valid),  64'd0);
    chk("abort_y_data",   bus.y_data,        64'd0);
    chk("abort_coef_err", 64'(bus.coef_err), 64'd0);
    rst = 1'b0;
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'd0;
    bus.coef_data = 32'd1;
    send(32'd4, 64'd4, 1'b1);
    bus.coef_we = 1'b0;
    wait_idle();

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter TAPS, 8, number of filter taps and delay-line depth (power of two, 2..64).
REQ-002 Parameter MUL_LAT, 2, fixed cycles from operand issue to product return on the shared signed multiplier (1..8).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 in_valid  in  1  new sample offered.
REQ-006 in_data  in  32  sample, two's complement.
REQ-007 in_ready  out  1  sample accepted when in_valid & in_ready.
REQ-008 coef_we  in  1  coefficient write strobe.
REQ-009 coef_addr  in  log2(TAPS)  coefficient index.
REQ-010 coef_data  in  32  coefficient, two's complement.
REQ-011 coef_err  out  1  one-cycle pulse: write rejected.
REQ-012 mul_vld  out  1  operands valid this cycle.
REQ-013 mul_a  out  32  sample operand to multiplier.
REQ-014 mul_b  out  32  coefficient operand to multiplier.
REQ-015 mul_p  in  64  signed product, valid exactly MUL_LAT cycles after the matching mul_vld.
REQ-016 y_valid  out  1  filter output valid.
REQ-017 y_data  out  64  filter output, two's complement.
REQ-018 y_ready  in  1  output consumed when y_valid & y_ready.

Function
REQ-019 The block SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-020 in_ready SHALL be 1 only in IDLE; on accept, delay line x[k] <= x[k-1], x[0] <= in_data, accumulator cleared, tap counter cleared, state -> ISSUE.
REQ-021 In ISSUE, each cycle the block SHALL drive mul_vld=1, mul_a=x[k], mul_b=h[k] for k=0..TAPS-1, one tap per cycle, ascending.
REQ-022 After issuing k=TAPS-1 the state SHALL go to DRAIN; mul_vld=0 and mul_a/mul_b=0 outside ISSUE.
REQ-023 An internal MUL_LAT-deep valid shift register SHALL track issued operands; each cycle its output is 1, acc <= acc + mul_p.
REQ-024 Accumulation SHALL be 64-bit two's complement, wrapping modulo 2^64, no saturation.
REQ-025 When the last product is accumulated, the state SHALL go to DONE with y_valid=1, y_data=acc, registered.
REQ-026 Latency: sample accepted in cycle 0 -> first mul_vld cycle 1 -> y_valid first asserted cycle TAPS+MUL_LAT+1 (11 at defaults).
REQ-027 In DONE, y_valid and y_data SHALL hold stable until y_ready=1; on that handshake the state SHALL return to IDLE and y_valid drop the next cycle.
REQ-028 Coefficient writes SHALL update h[coef_addr] only in IDLE; a write in any other state SHALL leave h unchanged and pulse coef_err for one cycle.
REQ-029 A coefficient write and a sample accept in the same IDLE cycle SHALL both take effect; the new coefficient is used for that sample.
REQ-030 mul_p SHALL be ignored when the internal valid-tracking output is 0.

Reset
REQ-031 On rst=1 at a clock edge: state IDLE, delay line, coefficients, accumulator, tap counter and valid-tracking register cleared to 0.
REQ-032 During and after reset: in_ready=1 (once rst=0), coef_err=0, mul_vld=0, mul_a=mul_b=0, y_valid=0, y_data=0.
REQ-033 Reset asserted mid-ISSUE or mid-DRAIN SHALL abort the computation; products returning after reset SHALL NOT be accumulated.

Verification
REQ-034 After reset, h[0]=3 written, others 0; sample 5 -> y_data=15, y_valid first at cycle 11 after accept.
REQ-035 h[0]=-2, sample 7 -> y_data=0xFFFF_FFFF_FFFF_FFF2 (-14).
REQ-036 All h[k]=1; samples 1..8 in sequence -> 8th output y_data=36; 9th sample 0 -> y_data=35.
REQ-037 y_ready held 0 for 5 cycles in DONE -> y_valid/y_data stable, in_ready=0, mul_vld=0 throughout; y_ready=1 -> IDLE next cycle.
REQ-038 coef_we during ISSUE -> coef_err pulses once, next output uses old coefficient.
REQ-039 rst pulsed at 3rd ISSUE cycle -> all outputs 0 next cycle; next sample 4 with h reloaded h[0]=1 -> y_data=4, no stale product included.
